// File: rtl/fixed_point_unit_controller_if.sv
// Bundle of decode, datapath and writeback signals around the fixed-point issue controller.
// The controller side uses the slave modport; the surrounding pipeline uses master.
interface fixed_point_unit_controller_if;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        fpu_start;
    logic [31:0] fpu_operand_1;
    logic [31:0] fpu_operand_2;
    logic [2:0]  fpu_funct3;
    logic [6:0]  fpu_funct7;
    logic [31:0] fpu_result;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;
    logic [4:0]  result_rd;
    logic        illegal;
    logic        busy;
    logic [4:0]  pending_rd;

    modport master (
        output flush, issue_valid, opcode, funct3, funct7, rd, operand_1, operand_2,
               fpu_result, result_ready,
        input  issue_ready, fpu_start, fpu_operand_1, fpu_operand_2, fpu_funct3,
               fpu_funct7, result_valid, result, result_rd, illegal, busy, pending_rd
    );

    modport slave (
        input  flush, issue_valid, opcode, funct3, funct7, rd, operand_1, operand_2,
               fpu_result, result_ready,
        output issue_ready, fpu_start, fpu_operand_1, fpu_operand_2, fpu_funct3,
               fpu_funct7, result_valid, result, result_rd, illegal, busy, pending_rd
    );
endinterface

// File: rtl/fixed_point_unit_controller.sv
// Issue/sequencing controller for the fixed-point execution datapath: holds one
// operation stable for its latency, captures the result and hands it to writeback.
module fixed_point_unit_controller #(
    parameter int unsigned ADD_LATENCY = 1,
    parameter int unsigned MUL_LATENCY = 3,
    parameter int unsigned DIV_LATENCY = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    fixed_point_unit_controller_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] WB   = 2'd2;

    localparam logic [6:0] OP_FP   = 7'b1010011;
    localparam logic [6:0] F7_FADD = 7'b0000000;
    localparam logic [6:0] F7_FSUB = 7'b0000100;
    localparam logic [6:0] F7_FMUL = 7'b0001000;
    localparam logic [6:0] F7_FDIV = 7'b0001100;

    localparam logic [5:0] ADD_CNT = 6'(ADD_LATENCY);
    localparam logic [5:0] MUL_CNT = 6'(MUL_LATENCY);
    localparam logic [5:0] DIV_CNT = 6'(DIV_LATENCY);

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        fpu_start_q, fpu_start_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [2:0]  f3_q, f3_d;
    logic [6:0]  f7_q, f7_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] result_q, result_d;
    logic        illegal_q, illegal_d;
    logic        result_valid_q, result_valid_d;
    logic        busy_q, busy_d;
    logic [4:0]  pending_rd_q, pending_rd_d;

    logic        issue_ready_c;
    logic        accept;
    logic        legal;
    logic [5:0]  lat_sel;

    always_comb begin
        legal   = 1'b0;
        lat_sel = ADD_CNT;
        if (bus.opcode == OP_FP) begin
            case (bus.funct7)
                F7_FADD, F7_FSUB: begin
                    legal   = 1'b1;
                    lat_sel = ADD_CNT;
                end
                F7_FMUL: begin
                    legal   = 1'b1;
                    lat_sel = MUL_CNT;
                end
                F7_FDIV: begin
                    legal   = 1'b1;
                    lat_sel = DIV_CNT;
                end
                default: begin
                    legal   = 1'b0;
                    lat_sel = ADD_CNT;
                end
            endcase
        end
    end

    always_comb begin
        issue_ready_c = ((state_q == IDLE) || ((state_q == WB) && bus.result_ready)) && !bus.flush;
        accept        = bus.issue_valid && issue_ready_c;

        state_d     = state_q;
        cnt_d       = cnt_q;
        fpu_start_d = 1'b0;
        op1_d       = op1_q;
        op2_d       = op2_q;
        f3_d        = f3_q;
        f7_d        = f7_q;
        rd_d        = rd_q;
        result_d    = result_q;
        illegal_d   = illegal_q;

        case (state_q)
            EXEC: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    result_d  = bus.fpu_result;
                    illegal_d = 1'b0;
                    state_d   = WB;
                end
            end
            WB: begin
                if (bus.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = state_q;
        endcase

        // An accept in WB overrides the return to IDLE, giving back-to-back issue.
        if (accept) begin
            rd_d = bus.rd;
            if (legal) begin
                op1_d       = bus.operand_1;
                op2_d       = bus.operand_2;
                f3_d        = bus.funct3;
                f7_d        = bus.funct7;
                cnt_d       = lat_sel;
                fpu_start_d = 1'b1;
                state_d     = EXEC;
            end else begin
                result_d  = '0;
                illegal_d = 1'b1;
                state_d   = WB;
            end
        end

        // Flush kills the in-flight op without touching the captured result.
        if (bus.flush && (state_q != IDLE)) begin
            state_d     = IDLE;
            fpu_start_d = 1'b0;
            result_d    = result_q;
            illegal_d   = illegal_q;
        end

        result_valid_d = (state_d == WB);
        busy_d         = (state_d != IDLE);
        pending_rd_d   = busy_d ? rd_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            fpu_start_q    <= 1'b0;
            op1_q          <= '0;
            op2_q          <= '0;
            f3_q           <= '0;
            f7_q           <= '0;
            rd_q           <= '0;
            result_q       <= '0;
            illegal_q      <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            pending_rd_q   <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            fpu_start_q    <= fpu_start_d;
            op1_q          <= op1_d;
            op2_q          <= op2_d;
            f3_q           <= f3_d;
            f7_q           <= f7_d;
            rd_q           <= rd_d;
            result_q       <= result_d;
            illegal_q      <= illegal_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            pending_rd_q   <= pending_rd_d;
        end
    end

    assign bus.issue_ready   = issue_ready_c;
    assign bus.fpu_start     = fpu_start_q;
    assign bus.fpu_operand_1 = op1_q;
    assign bus.fpu_operand_2 = op2_q;
    assign bus.fpu_funct3    = f3_q;
    assign bus.fpu_funct7    = f7_q;
    assign bus.result_valid  = result_valid_q;
    assign bus.result        = result_q;
    assign bus.result_rd     = rd_q;
    assign bus.illegal       = illegal_q;
    assign bus.busy          = busy_q;
    assign bus.pending_rd    = pending_rd_q;

endmodule

// File: tb/tb_fixed_point_unit_controller.sv
// Scoreboard bench for fixed_point_unit_controller: directed scenarios followed by
// random traffic, with a latency-aware datapath model and a queue-based result monitor.
module tb_fixed_point_unit_controller;

    localparam int unsigned ADD_L = 1;
    localparam int unsigned MUL_L = 3;
    localparam int unsigned DIV_L = 16;
    localparam logic [6:0]  FP    = 7'b1010011;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fixed_point_unit_controller_if bus();

    fixed_point_unit_controller #(
        .ADD_LATENCY(ADD_L),
        .MUL_LATENCY(MUL_L),
        .DIV_LATENCY(DIV_L)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
        int          wb_from;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference model of the in-flight operation, valid for the current cycle.
    bit          m_inflight = 0;
    bit          m_legal    = 0;
    bit          m_after_reset = 0;
    int          m_start    = 0;
    int          m_wb_from  = 0;
    logic [4:0]  m_rd       = '0;
    logic [31:0] m_a        = '0;
    logic [31:0] m_b        = '0;
    logic [2:0]  m_f3       = '0;
    logic [6:0]  m_f7       = '0;

    function automatic int lat_of(input logic [6:0] op, input logic [6:0] f7);
        if (op != FP) return 0;
        case (f7)
            7'h00, 7'h04: return int'(ADD_L);
            7'h08:        return int'(MUL_L);
            7'h0C:        return int'(DIV_L);
            default:      return 0;
        endcase
    endfunction

    // Q16.16 arithmetic stand-in for the real datapath.
    function automatic logic [31:0] golden(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] xa;
        logic signed [63:0] xb;
        logic signed [63:0] p;
        xa = $signed(a);
        xb = $signed(b);
        case (f7)
            7'h00: return a + b;
            7'h04: return a - b;
            7'h08: begin
                p = xa * xb;
                return p[47:16];
            end
            7'h0C: begin
                if (b == 32'd0) return '1;
                p = (xa <<< 16) / xb;
                return p[31:0];
            end
            default: return '0;
        endcase
    endfunction

    // Datapath model: the answer is only correct in the L-th cycle after fpu_start.
    int dp_age = 0;
    int age_now;
    always @(posedge clk) dp_age <= bus.fpu_start ? 1 : dp_age + 1;
    always_comb begin
        age_now = bus.fpu_start ? 0 : dp_age;
        if (age_now == lat_of(FP, bus.fpu_funct7) - 1)
            bus.fpu_result = golden(bus.fpu_funct7, bus.fpu_operand_1, bus.fpu_operand_2);
        else
            bus.fpu_result = ~golden(bus.fpu_funct7, bus.fpu_operand_1, bus.fpu_operand_2);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit rst_n, input bit fl, input bit iv, input logic [6:0] op,
                        input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] r,
                        input logic [31:0] a, input logic [31:0] b, input bit rr);
        bit in_wb;
        bit exp_ready;
        int lat;
        @(posedge clk);
        cyc++;
        #1;
        reset            = rst_n;
        bus.flush        = fl;
        bus.issue_valid  = iv;
        bus.opcode       = op;
        bus.funct7       = f7;
        bus.funct3       = f3;
        bus.rd           = r;
        bus.operand_1    = a;
        bus.operand_2    = b;
        bus.result_ready = rr;
        #1;
        in_wb     = m_inflight && (cyc >= m_wb_from);
        exp_ready = !fl && (!m_inflight || (in_wb && rr));
        chk("issue_ready", bus.issue_ready, exp_ready);
        if (m_after_reset) begin
            chk("reset_outputs", {bus.fpu_start, bus.result_valid, bus.illegal, bus.result,
                                  bus.fpu_operand_1, bus.fpu_operand_2, bus.fpu_funct3,
                                  bus.fpu_funct7, bus.result_rd, bus.pending_rd, bus.busy}, '0);
        end else begin
            chk("busy", bus.busy, m_inflight);
            chk("pending_rd", bus.pending_rd, m_inflight ? m_rd : 5'd0);
            chk("result_valid", bus.result_valid, in_wb);
            chk("fpu_start", bus.fpu_start, m_inflight && m_legal && (cyc == m_start));
            if (m_inflight && m_legal && !in_wb)
                chk("fpu_hold", {bus.fpu_operand_1, bus.fpu_operand_2, bus.fpu_funct3, bus.fpu_funct7},
                                {m_a, m_b, m_f3, m_f7});
        end

        m_after_reset = 0;
        if (!rst_n) begin
            m_inflight    = 0;
            m_after_reset = 1;
            sb.delete();
        end else if (fl) begin
            m_inflight = 0;
        end else begin
            if (in_wb && rr) m_inflight = 0;
            if (iv && exp_ready) begin
                lat        = lat_of(op, f7);
                m_inflight = 1;
                m_legal    = (lat != 0);
                m_rd       = r;
                m_start    = cyc + 1;
                m_wb_from  = cyc + 1 + lat;
                if (m_legal) begin
                    m_a  = a;
                    m_b  = b;
                    m_f3 = f3;
                    m_f7 = f7;
                end
                sb.push_back('{res: m_legal ? golden(f7, a, b) : 32'd0, rd: r, ill: !m_legal,
                               wb_from: m_wb_from});
            end
        end
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) step(1, 0, 0, FP, 7'h00, 3'd0, 5'd0, 32'd0, 32'd0, rr);
    endtask

    task automatic issue(input logic [6:0] f7, input logic [4:0] r, input logic [31:0] a,
                         input logic [31:0] b, input bit rr);
        step(1, 0, 1, FP, f7, 3'd1, r, a, b, rr);
    endtask

    // Monitor: pops the scoreboard on handshake, flush or kill.
    bit seen = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                seen = 0;
            end else if (bus.result_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid cyc=%0d got=result_valid expected=none", cyc);
                end else begin
                    if (!seen) begin
                        chk("wb_cycle", cyc, sb[0].wb_from);
                        seen = 1;
                    end
                    chk("result", {bus.result, bus.result_rd, bus.illegal},
                                  {sb[0].res, sb[0].rd, sb[0].ill});
                    if (bus.flush || bus.result_ready) begin
                        void'(sb.pop_front());
                        seen = 0;
                    end
                end
            end else if (bus.flush && sb.size() > 0) begin
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [6:0] f7r;
        logic [6:0] opr;
        reset            = 1'b0;
        bus.flush        = 1'b0;
        bus.issue_valid  = 1'b0;
        bus.opcode       = '0;
        bus.funct3       = '0;
        bus.funct7       = '0;
        bus.rd           = '0;
        bus.operand_1    = '0;
        bus.operand_2    = '0;
        bus.result_ready = 1'b0;
        step(0, 0, 0, FP, 7'h00, 3'd0, 5'd0, 32'd0, 32'd0, 0);
        step(0, 0, 0, FP, 7'h00, 3'd0, 5'd0, 32'd0, 32'd0, 0);
        idle(2, 1);

        issue(7'h00, 5'd5, 32'h0001_0000, 32'h0002_0000, 1);
        idle(4, 1);

        issue(7'h08, 5'd9, 32'h0003_0000, 32'hFFFE_8000, 0);
        idle(7, 0);
        idle(2, 1);

        step(1, 0, 1, FP, 7'h7F, 3'd2, 5'd12, 32'h1234, 32'h5678, 1);
        idle(2, 1);

        issue(7'h00, 5'd1, 32'd100, 32'd200, 1);
        idle(1, 1);
        issue(7'h04, 5'd2, 32'd50, 32'd80, 1);
        idle(3, 1);

        issue(7'h0C, 5'd7, 32'h0010_0000, 32'h0004_0000, 1);
        idle(7, 1);
        step(1, 1, 0, FP, 7'h00, 3'd0, 5'd0, 32'd0, 32'd0, 1);
        issue(7'h00, 5'd8, 32'd3, 32'd4, 1);
        idle(3, 1);

        issue(7'h08, 5'd11, 32'h0002_0000, 32'h0002_0000, 1);
        idle(1, 1);
        step(0, 0, 0, FP, 7'h00, 3'd0, 5'd0, 32'd0, 32'd0, 1);
        idle(5, 1);

        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 4))
                0:       f7r = 7'h00;
                1:       f7r = 7'h04;
                2:       f7r = 7'h08;
                3:       f7r = 7'h0C;
                default: f7r = 7'($urandom);
            endcase
            opr = ($urandom_range(0, 9) == 0) ? 7'($urandom) : FP;
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 9) < 6), opr, f7r, 3'($urandom), 5'($urandom),
                 $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                 ($urandom_range(0, 3) != 0));
        end

        idle(40, 1);
        chk("drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
